// File: rtl/cpl_sequencer.sv
// cpl_sequencer
//   Sequences the completion-context tag storage of the PCIe-to-AXI-Lite
//   bridge. Inbound descriptors are forwarded to the AXI-Lite master one at a
//   time. A non-posted descriptor writes a context into the storage and bumps
//   the outstanding count. In-order AXI responses launch a completion, and
//   the context is retired (storage read pointer advanced) when the
//   completion generator accepts it.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   cfg_max_outstanding  soft context limit (0 = hard capacity)
//   req_valid/req_np/req_ready          RX descriptor handshake
//   tag_mang_write_en                   storage write pulse (non-posted accept)
//   axi_issue_valid/axi_issue_ready     request to AXI-Lite master
//   rsp_valid/rsp_ready                 in-order AXI response
//   cpl_valid/cpl_ready                 completion generator handshake
//   tag_mang_read_en                    storage read-pointer advance pulse
//   outstanding/full/empty              context count status
//   err_unexpected_rsp                  sticky: response arrived while empty
module cpl_sequencer #(
    parameter int TCQ           = 1,
    parameter int RAM_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [RAM_ADDR_BITS-1:0] cfg_max_outstanding,
    input  logic                     req_valid,
    input  logic                     req_np,
    output logic                     req_ready,
    output logic                     tag_mang_write_en,
    output logic                     axi_issue_valid,
    input  logic                     axi_issue_ready,
    input  logic                     rsp_valid,
    output logic                     rsp_ready,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic                     tag_mang_read_en,
    output logic [RAM_ADDR_BITS-1:0] outstanding,
    output logic                     full,
    output logic                     empty,
    output logic                     err_unexpected_rsp
);

    // Storage holds 2**N entries but one slot is sacrificed so the
    // read/write pointers can distinguish full from empty.
    localparam logic [RAM_ADDR_BITS-1:0] CAP = '1;

    typedef enum logic {REQ_IDLE, REQ_ISSUE} req_state_t;
    typedef enum logic {CPL_IDLE, CPL_SEND}  cpl_state_t;

    req_state_t req_state;
    cpl_state_t cpl_state;

    logic [RAM_ADDR_BITS-1:0] limit;
    logic                     req_hs;
    logic                     rsp_hs;

    // An N-bit cfg value can never exceed CAP, so only 0 needs remapping.
    assign limit = (cfg_max_outstanding == '0) ? CAP : cfg_max_outstanding;
    assign full  = (outstanding >= limit);
    assign empty = (outstanding == '0);

    // Ready signals are gated by reset so nothing is accepted while held.
    assign req_ready = reset_n && (req_state == REQ_IDLE) && (!req_np || !full);
    assign rsp_ready = reset_n && (cpl_state == CPL_IDLE);

    assign req_hs = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    assign tag_mang_write_en = req_hs && req_np;
    assign axi_issue_valid   = (req_state == REQ_ISSUE);
    assign cpl_valid         = (cpl_state == CPL_SEND);
    // Retire coincides with the completion handshake, so the storage read
    // data stays stable for the whole CPL_SEND period.
    assign tag_mang_read_en  = (cpl_state == CPL_SEND) && cpl_ready;

    // Request FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_state <= REQ_IDLE;
        end else begin
            case (req_state)
                REQ_IDLE:  if (req_hs)          req_state <= REQ_ISSUE;
                REQ_ISSUE: if (axi_issue_ready) req_state <= REQ_IDLE;
                default:                        req_state <= REQ_IDLE;
            endcase
        end
    end

    // Completion FSM; a response with no context outstanding is dropped
    // and flagged instead of launching a completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpl_state          <= CPL_IDLE;
            err_unexpected_rsp <= 1'b0;
        end else begin
            case (cpl_state)
                CPL_IDLE: begin
                    if (rsp_hs) begin
                        if (empty) err_unexpected_rsp <= 1'b1;
                        else       cpl_state          <= CPL_SEND;
                    end
                end
                CPL_SEND: if (cpl_ready) cpl_state <= CPL_IDLE;
                default:                 cpl_state <= CPL_IDLE;
            endcase
        end
    end

    // Context counter; full gating on writes and the empty check on
    // responses keep it from wrapping in either direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({tag_mang_write_en, tag_mang_read_en})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_cpl_sequencer.sv
module tb_cpl_sequencer;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cfg_max_outstanding;
    logic          req_valid, req_np, req_ready, tag_mang_write_en;
    logic          axi_issue_valid, axi_issue_ready;
    logic          rsp_valid, rsp_ready, cpl_valid, cpl_ready;
    logic          tag_mang_read_en;
    logic [AW-1:0] outstanding;
    logic          full, empty, err_unexpected_rsp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpl_sequencer #(.TCQ(1), .RAM_ADDR_BITS(AW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cfg_max_outstanding (cfg_max_outstanding),
        .req_valid           (req_valid),
        .req_np              (req_np),
        .req_ready           (req_ready),
        .tag_mang_write_en   (tag_mang_write_en),
        .axi_issue_valid     (axi_issue_valid),
        .axi_issue_ready     (axi_issue_ready),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .cpl_valid           (cpl_valid),
        .cpl_ready           (cpl_ready),
        .tag_mang_read_en    (tag_mang_read_en),
        .outstanding         (outstanding),
        .full                (full),
        .empty               (empty),
        .err_unexpected_rsp  (err_unexpected_rsp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request, accepted and issued with axi_issue_ready already high.
    task automatic send_req(input logic np);
        req_valid = 1'b1;
        req_np    = np;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    // All outputs in the reset state
    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"},   req_ready, 0);
        chk({tag, ".write_en"},    tag_mang_write_en, 0);
        chk({tag, ".axi_valid"},   axi_issue_valid, 0);
        chk({tag, ".rsp_ready"},   rsp_ready, 0);
        chk({tag, ".cpl_valid"},   cpl_valid, 0);
        chk({tag, ".read_en"},     tag_mang_read_en, 0);
        chk({tag, ".outstanding"}, outstanding, 0);
        chk({tag, ".full"},        full, 0);
        chk({tag, ".empty"},       empty, 1);
        chk({tag, ".err"},         err_unexpected_rsp, 0);
    endtask

    // Single non-posted round trip starting from empty
    task automatic single_np(input string tag);
        axi_issue_ready = 1'b1;
        req_valid = 1'b1; req_np = 1'b1;
        #1;
        chk({tag, ".req_ready"}, req_ready, 1);
        chk({tag, ".write_en"},  tag_mang_write_en, 1);
        tick();
        req_valid = 1'b0;
        #1;
        chk({tag, ".axi_valid"},   axi_issue_valid, 1);
        chk({tag, ".req_ready_busy"}, req_ready, 0);
        chk({tag, ".write_en_off"}, tag_mang_write_en, 0);
        chk({tag, ".outstanding1"}, outstanding, 1);
        chk({tag, ".empty0"},      empty, 0);
        tick();
        chk({tag, ".axi_valid_off"}, axi_issue_valid, 0);
        rsp_valid = 1'b1;
        #1;
        chk({tag, ".rsp_ready"}, rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        chk({tag, ".cpl_valid"},     cpl_valid, 1);
        chk({tag, ".rsp_ready_busy"}, rsp_ready, 0);
        cpl_ready = 1'b1;
        #1;
        chk({tag, ".read_en"}, tag_mang_read_en, 1);
        tick();
        cpl_ready = 1'b0;
        #1;
        chk({tag, ".cpl_valid_off"}, cpl_valid, 0);
        chk({tag, ".outstanding0"},  outstanding, 0);
        chk({tag, ".empty1"},        empty, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_max_outstanding = '0;
        req_valid = 1'b0; req_np = 1'b0;
        axi_issue_ready = 1'b0;
        rsp_valid = 1'b0; cpl_ready = 1'b0;
        #3;
        chk_reset_outputs("rst");
        tick(); tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Scenario 1: basic round trip
        single_np("s1");

        // Scenario 2: fill to hard capacity (31) with no responses
        axi_issue_ready = 1'b1;
        for (int i = 0; i < 31; i++) send_req(1'b1);
        chk("s2.outstanding31", outstanding, 31);
        chk("s2.full", full, 1);
        req_valid = 1'b1; req_np = 1'b1;
        #1;
        chk("s2.np_blocked", req_ready, 0);
        chk("s2.np_no_write", tag_mang_write_en, 0);
        req_np = 1'b0;
        #1;
        chk("s2.posted_ready", req_ready, 1);
        chk("s2.posted_no_write", tag_mang_write_en, 0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("s2.posted_issue", axi_issue_valid, 1);
        chk("s2.posted_count", outstanding, 31);
        tick();
        // Drain: each context takes a rsp cycle and a cpl cycle
        rsp_valid = 1'b1; cpl_ready = 1'b1;
        for (int i = 0; i < 62; i++) tick();
        rsp_valid = 1'b0; cpl_ready = 1'b0;
        #1;
        chk("s2.drained", outstanding, 0);
        chk("s2.empty", empty, 1);
        chk("s2.no_err", err_unexpected_rsp, 0);
        tick();

        // Scenario 3: soft limit 4
        cfg_max_outstanding = 5'd4;
        for (int i = 0; i < 4; i++) send_req(1'b1);
        chk("s3.outstanding4", outstanding, 4);
        chk("s3.full", full, 1);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        // Fifth NP pending while a context retires in the same cycle
        req_valid = 1'b1; req_np = 1'b1; cpl_ready = 1'b1;
        #1;
        chk("s3.fifth_blocked", req_ready, 0);
        chk("s3.retire", tag_mang_read_en, 1);
        tick();
        cpl_ready = 1'b0;
        #1;
        chk("s3.count3", outstanding, 3);
        chk("s3.fifth_ready", req_ready, 1);
        chk("s3.fifth_write", tag_mang_write_en, 1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("s3.outstanding4b", outstanding, 4);
        chk("s3.full_again", full, 1);
        tick();
        // Lowering the limit below the count stalls NPs
        cfg_max_outstanding = 5'd2;
        req_valid = 1'b1; req_np = 1'b1;
        #1;
        chk("s3.lowered_block", req_ready, 0);
        chk("s3.lowered_count", outstanding, 4);
        // Simultaneous write and retire leave the count unchanged
        cfg_max_outstanding = 5'd0;
        req_valid = 1'b0;
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        req_valid = 1'b1; req_np = 1'b1; cpl_ready = 1'b1;
        #1;
        chk("s3.both_write", tag_mang_write_en, 1);
        chk("s3.both_read",  tag_mang_read_en, 1);
        tick();
        req_valid = 1'b0; cpl_ready = 1'b0;
        #1;
        chk("s3.both_count", outstanding, 4);
        tick();
        rsp_valid = 1'b1; cpl_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rsp_valid = 1'b0; cpl_ready = 1'b0;
        #1;
        chk("s3.drained", outstanding, 0);
        tick();

        // Scenario 4: response while empty
        rsp_valid = 1'b1;
        #1;
        chk("s4.rsp_ready", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("s4.no_cpl", cpl_valid, 0);
        chk("s4.err", err_unexpected_rsp, 1);
        chk("s4.count", outstanding, 0);
        tick(); tick();
        chk("s4.err_sticky", err_unexpected_rsp, 1);

        // Scenario 5: completion back-pressure
        send_req(1'b1);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("s5.cpl_hold", cpl_valid, 1);
            chk("s5.rsp_blocked", rsp_ready, 0);
            chk("s5.no_read", tag_mang_read_en, 0);
            tick();
        end
        cpl_ready = 1'b1;
        #1;
        chk("s5.read_en", tag_mang_read_en, 1);
        tick();
        cpl_ready = 1'b0;
        #1;
        chk("s5.cpl_off", cpl_valid, 0);
        chk("s5.count", outstanding, 0);

        // Scenario 6: reset mid-operation
        for (int i = 0; i < 3; i++) send_req(1'b1);
        axi_issue_ready = 1'b0;
        req_valid = 1'b1; req_np = 1'b0;
        tick();
        req_valid = 1'b0;
        #1;
        chk("s6.in_issue", axi_issue_valid, 1);
        chk("s6.count3", outstanding, 3);
        req_valid = 1'b1; req_np = 1'b1; rsp_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("s6.rst");
        tick();
        chk_reset_outputs("s6.rst_held");
        req_valid = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        single_np("s6.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
